// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: FSM states, instruction field
// positions, destination encodings and the HALT mode.
package alu_seq_pkg;

  localparam int unsigned INSTR_W  = 22;
  localparam int unsigned MODE_W   = 4;
  localparam int unsigned DEST_MSB = 21;
  localparam int unsigned DEST_LSB = 20;
  localparam int unsigned MODE_MSB = 19;
  localparam int unsigned MODE_LSB = 16;
  localparam int unsigned A_MSB    = 15;
  localparam int unsigned A_LSB    = 8;
  localparam int unsigned B_MSB    = 7;
  localparam int unsigned B_LSB    = 0;

  localparam logic [1:0] DEST_NONE = 2'b00;
  localparam logic [1:0] DEST_TM1  = 2'b01;
  localparam logic [1:0] DEST_TM2  = 2'b10;

  localparam logic [MODE_W-1:0] MODE_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_WRITE,
    S_DONE
  } state_e;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return (instr[DEST_MSB:DEST_LSB] == DEST_NONE) &&
           (instr[MODE_MSB:MODE_LSB] == MODE_HALT);
  endfunction

endpackage

// File: rtl/seq_addr_counter.sv
// Address counter with synchronous clear and a sticky flag set when the
// count wraps from its maximum back to zero.
module seq_addr_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         full
);

  logic [W-1:0] count_q, count_d;
  logic         full_q, full_d;

  always_comb begin
    count_d = count_q;
    full_d  = full_q;
    if (clear) begin
      count_d = '0;
      full_d  = 1'b0;
    end else if (en) begin
      count_d = count_q + W'(1);
      if (count_q == '1) full_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign count = count_q;
  assign full  = full_q;

endmodule

// File: rtl/alu_sequencer.sv
// Steps through an instruction memory, drives an external ALU and writes the
// results into up to two transaction memories; three cycles per instruction.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [MODE_W-1:0]  alu_mode,
  input  logic [DATA_W-1:0]  alu_out,
  output logic               tm1_wen,
  output logic               tm2_wen,
  output logic [ADDR_W-1:0]  tm1_addr,
  output logic [ADDR_W-1:0]  tm2_addr,
  output logic [DATA_W-1:0]  tm_din,
  output logic               busy,
  output logic               done,
  output logic               tm1_full,
  output logic               tm2_full
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [MODE_W-1:0]   alu_mode_q, alu_mode_d;
  logic                imem_en_q, imem_en_d;
  logic                tm1_wen_q, tm1_wen_d, tm2_wen_q, tm2_wen_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                clr_c, imem_inc_c, halt_c, imem_last_c;
  logic [1:0]          dest_c;
  logic                unused_imem_full;

  assign halt_c      = is_halt(imem_data);
  assign dest_c      = imem_data[DEST_MSB:DEST_LSB];
  assign imem_last_c = (imem_addr == '1);

  // Next state, operand capture and registered output strobes.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_mode_d = alu_mode_q;
    clr_c      = 1'b0;
    imem_inc_c = 1'b0;
    tm1_wen_d  = 1'b0;
    tm2_wen_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          clr_c   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        if (halt_c) begin
          state_d = S_DONE;
        end else begin
          alu_a_d    = DATA_W'(imem_data[A_MSB:A_LSB]);
          alu_b_d    = DATA_W'(imem_data[B_MSB:B_LSB]);
          alu_mode_d = imem_data[MODE_MSB:MODE_LSB];
          tm1_wen_d  = ((dest_c & DEST_TM1) != DEST_NONE) && !tm1_full;
          tm2_wen_d  = ((dest_c & DEST_TM2) != DEST_NONE) && !tm2_full;
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        if (imem_last_c) begin
          state_d = S_DONE;
        end else begin
          imem_inc_c = 1'b1;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
    imem_en_d = (state_d == S_FETCH);
    busy_d    = (state_d == S_FETCH) || (state_d == S_LATCH) || (state_d == S_WRITE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_mode_q <= '0;
      imem_en_q  <= 1'b0;
      tm1_wen_q  <= 1'b0;
      tm2_wen_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_mode_q <= alu_mode_d;
      imem_en_q  <= imem_en_d;
      tm1_wen_q  <= tm1_wen_d;
      tm2_wen_q  <= tm2_wen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Transaction counters advance on the cycle their write strobe is high.
  seq_addr_counter #(.W(ADDR_W)) u_imem_cnt (
    .clock (clock), .reset (reset), .clear (clr_c), .en (imem_inc_c),
    .count (imem_addr), .full (unused_imem_full)
  );

  seq_addr_counter #(.W(ADDR_W)) u_tm1_cnt (
    .clock (clock), .reset (reset), .clear (clr_c), .en (tm1_wen_q),
    .count (tm1_addr), .full (tm1_full)
  );

  seq_addr_counter #(.W(ADDR_W)) u_tm2_cnt (
    .clock (clock), .reset (reset), .clear (clr_c), .en (tm2_wen_q),
    .count (tm2_addr), .full (tm2_full)
  );

  assign imem_en  = imem_en_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_mode = alu_mode_q;
  assign tm1_wen  = tm1_wen_q;
  assign tm2_wen  = tm2_wen_q;
  assign tm_din   = alu_out;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed bench for alu_sequencer against a program-level
// reference model of the instruction/transaction memories.
module tb_alu_sequencer;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int DEPTH = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_en;
  logic [21:0]       imem_data = '0;
  logic [DATA_W-1:0] alu_a, alu_b, alu_out, tm_din;
  logic [3:0]        alu_mode;
  logic              tm1_wen, tm2_wen, busy, done, tm1_full, tm2_full;
  logic [ADDR_W-1:0] tm1_addr, tm2_addr;

  alu_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_data(imem_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_out(alu_out),
    .tm1_wen(tm1_wen), .tm2_wen(tm2_wen), .tm1_addr(tm1_addr), .tm2_addr(tm2_addr),
    .tm_din(tm_din), .busy(busy), .done(done), .tm1_full(tm1_full), .tm2_full(tm2_full)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] m);
    case (m)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      default: return a + b + 8'(m);
    endcase
  endfunction

  logic [21:0] imem [DEPTH];
  always @(posedge clock) if (imem_en) imem_data <= imem[imem_addr];
  assign alu_out = alu_ref(alu_a, alu_b, alu_mode);

  typedef struct { int addr; int data; int off; } wr_t;
  wr_t got1[$], got2[$], exp1[$], exp2[$];
  int  got_fetch[$], exp_fetch[$];
  int  cyc = 0, start_cyc = 0;
  int  checks = 0, errors = 0;
  logic [7:0] m_a = 0, m_b = 0;
  logic [3:0] m_mode = 0;

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (tm1_wen) got1.push_back('{int'(tm1_addr), int'(tm_din), cyc - start_cyc});
    if (tm2_wen) got2.push_back('{int'(tm2_addr), int'(tm_din), cyc - start_cyc});
    if (imem_en) got_fetch.push_back(int'(imem_addr));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input wr_t g[$], input wr_t e[$]);
    check({tag, "_count"}, 32'(g.size()), 32'(e.size()));
    for (int i = 0; i < g.size() && i < e.size(); i++) begin
      check($sformatf("%s[%0d]_addr", tag, i), 32'(g[i].addr), 32'(e[i].addr));
      check($sformatf("%s[%0d]_data", tag, i), 32'(g[i].data), 32'(e[i].data));
      check($sformatf("%s[%0d]_cyc", tag, i), 32'(g[i].off), 32'(e[i].off));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_outs"}, {alu_a, alu_b, alu_mode, tm1_addr, tm2_addr, imem_addr},
          '0);
    check({tag, "_strobes"}, {imem_en, tm1_wen, tm2_wen, busy, done, tm1_full, tm2_full},
          '0);
    check({tag, "_tm_din"}, 32'(tm_din), 32'(alu_ref(alu_a, alu_b, alu_mode)));
  endtask

  // Program-level model: each executed instruction costs 3 cycles, a HALT 2.
  task automatic run_prog(input string tag, input int pulse_at);
    int n1 = 0, n2 = 0, done_at = 0, k;
    exp1.delete(); exp2.delete(); exp_fetch.delete();
    got1.delete(); got2.delete(); got_fetch.delete();
    for (int i = 0; i < DEPTH; i++) begin
      logic [1:0] d; logic [3:0] m; logic [7:0] a, b, r;
      {d, m, a, b} = imem[i];
      exp_fetch.push_back(i);
      if (d == 2'b00 && m == 4'hF) begin done_at += 2; break; end
      r = alu_ref(a, b, m);
      m_a = a; m_b = b; m_mode = m;
      if (d[0] && n1 < DEPTH) begin exp1.push_back('{n1, int'(r), done_at + 2}); n1++; end
      if (d[1] && n2 < DEPTH) begin exp2.push_back('{n2, int'(r), done_at + 2}); n2++; end
      done_at += 3;
    end
    @(negedge clock) start = 1'b1;
    @(posedge clock); #1;
    start_cyc = cyc;
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    for (k = 1; k <= 200; k++) begin
      @(negedge clock) start = (k == pulse_at);
      @(posedge clock); #1;
      if (done) break;
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_done_cyc"}, 32'(k), 32'(done_at));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_wr({tag, "_tm1"}, got1, exp1);
    check_wr({tag, "_tm2"}, got2, exp2);
    check({tag, "_fetch_n"}, 32'(got_fetch.size()), 32'(exp_fetch.size()));
    for (int i = 0; i < got_fetch.size() && i < exp_fetch.size(); i++)
      check($sformatf("%s_fetch[%0d]", tag, i), 32'(got_fetch[i]), 32'(exp_fetch[i]));
    check({tag, "_ops"}, {alu_a, alu_b, alu_mode}, {m_a, m_b, m_mode});
    check({tag, "_tm1_addr"}, 32'(tm1_addr), 32'(n1 % DEPTH));
    check({tag, "_tm2_addr"}, 32'(tm2_addr), 32'(n2 % DEPTH));
    check({tag, "_full"}, {tm1_full, tm2_full}, {n1 >= DEPTH, n2 >= DEPTH});
    repeat (3) @(posedge clock);
    #1 check({tag, "_hold"}, {done, busy, alu_a, alu_b, tm1_wen, tm2_wen, imem_en},
             {1'b1, 1'b0, m_a, m_b, 3'b000});
  endtask

  task automatic rand_prog(input int halt_at);
    for (int i = 0; i < DEPTH; i++)
      imem[i] = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 14)),
                 8'($urandom), 8'($urandom)};
    if (halt_at < DEPTH) imem[halt_at] = {2'b00, 4'hF, 16'($urandom)};
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) imem[i] = '0;
    repeat (3) @(posedge clock);
    #1 check_idle_outputs("reset");
    @(negedge clock) reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 check_idle_outputs("idle_wait");

    // Single add to TM1 followed by HALT.
    imem[0] = {2'b01, 4'h0, 8'h05, 8'h03};
    imem[1] = {2'b00, 4'hF, 16'h0};
    run_prog("basic", -1);
    check("basic_din", 32'(got1.size() > 0 ? got1[0].data : 0), 32'h08);

    // Sixteen writes to both memories fill them.
    rand_prog(DEPTH);
    for (int i = 0; i < DEPTH; i++) imem[i][21:20] = 2'b11;
    run_prog("full16", -1);

    // Restart from DONE with discard-only instructions clears counters and flags.
    for (int i = 0; i < DEPTH; i++) imem[i][21:20] = 2'b00;
    imem[4] = {2'b00, 4'hF, 16'h0};
    run_prog("discard", -1);

    // Start pulses while busy must not restart.
    rand_prog(10);
    run_prog("busy_start", 4);
    rand_prog(12);
    run_prog("busy_start2", 20);

    // Random programs, restarting from DONE each time.
    for (int t = 0; t < 6; t++) begin
      rand_prog($urandom_range(0, 17));
      run_prog($sformatf("rand%0d", t), -1);
    end

    // Reset during WRITE of the second instruction aborts it.
    imem[0] = {2'b11, 4'h2, 8'hF0, 8'h3C};
    imem[1] = {2'b11, 4'h0, 8'h11, 8'h22};
    imem[2] = {2'b00, 4'hF, 16'h0};
    got1.delete(); got2.delete();
    @(negedge clock) start = 1'b1;
    @(posedge clock); #1 start_cyc = cyc;
    @(negedge clock) start = 1'b0;
    repeat (5) @(posedge clock);
    #2 check("pre_abort_wen", {tm1_wen, tm2_wen}, 2'b11);
    reset = 1'b0;
    #1 check_idle_outputs("abort");
    check("abort_wr1", 32'(got1.size()), 32'd1);
    check("abort_wr2", 32'(got2.size()), 32'd1);
    @(negedge clock) reset = 1'b1;
    repeat (6) @(posedge clock);
    #1 check_idle_outputs("abort_idle");
    check("abort_no_wr", 32'(got1.size() + got2.size()), 32'd2);
    m_a = 0; m_b = 0; m_mode = 0;
    rand_prog($urandom_range(3, 16));
    run_prog("after_abort", -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
